hilo_divider: RTL
=================

// Module: hilo_divider
// PURPOSE
//  Multi-cycle responder for the decoder's HasDivD / is_mf_hi / is_mf_lo outputs.
//  - Performs DIV iteratively and owns the architectural HI/LO registers.
//  - Serves MFHI/MFLO reads.
//  - Raises stall to the hazard unit while a divide is in flight.
//  - Sits in the execute stage beside the ALU.
// PARAMETERS
//  WIDTH       32  operand/result width; must be even
//  RADIX_BITS  1   quotient bits retired per RUN cycle; legal values 1 or 2
// PORTS
//  clock       in   1      rising-edge clock
//  reset_n     in   1      async active-low reset
//  start       in   1      HasDivE: DIV in execute; 1-cycle qualifier
//  dividend    in   WIDTH  rs value, sampled when start=1 in IDLE
//  divisor     in   WIDTH  rt value, sampled when start=1 in IDLE
//  is_mf_hi    in   1      MFHI in execute
//  is_mf_lo    in   1      MFLO in execute
//  hilo_out    out  WIDTH  HI if is_mf_hi, else LO if is_mf_lo, else 0
//  busy        out  1      FSM not IDLE
//  stall       out  1      (is_mf_hi|is_mf_lo|start) & busy & !done
//  done        out  1      1-cycle pulse in the cycle HI/LO are written
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain.
//  - reset_n is asynchronous and active-low.
//  - Reset forces state=IDLE, HI=0, LO=0, counter=0, busy=0, done=0.
//  FSM: IDLE -> PREP -> RUN -> FIX -> IDLE
//  - IDLE: start=1 latches |dividend|, |divisor| and both sign bits, then -> PREP.
//  - PREP: clear the partial remainder, load the quotient shift register,
//    set counter=WIDTH/RADIX_BITS.
//  - RUN: restoring shift-subtract, RADIX_BITS steps per cycle.
//    - counter decrements each cycle.
//    - When counter reaches 0 -> FIX.
//  - FIX: apply signs and write HI/LO.
//    - LO gets quotient, negated if the two signs differ.
//    - HI gets remainder, negated if the dividend is negative.
//    - done=1 this cycle; next state IDLE.
//  Latency
//  - start accepted at cycle 0; HI/LO update on the clock edge ending cycle
//    WIDTH/RADIX_BITS+2.
//  - RADIX_BITS=1, WIDTH=32: 34 cycles.
//  Arithmetic
//  - Absolute value of 0x8000_0000 is treated as unsigned 2^31; no overflow trap.
//  - 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
//  - Divisor 0 -> LO=all-ones, HI=dividend unchanged; takes full latency.
//  Reads and bypass
//  - hilo_out is combinational from HI/LO.
//  - In the done cycle, hilo_out returns the new FIX value (bypass), so a
//    stalled MF completes that cycle.
//  Boundary conditions
//  - start while busy: ignored, operands not resampled. stall stays high so
//    the hazard unit holds the DIV.
//  - start and is_mf_* together in IDLE: divide starts; hilo_out returns the
//    old HI/LO.
//  - is_mf_hi and is_mf_lo together: illegal; hilo_out returns HI.
//  - reset_n low mid-divide: in-flight result discarded, HI/LO=0.
// CONFIGURATION
//  Macro: HILO_DIVU_EN
//  - Defined: adds input div_unsigned (1 bit), sampled with start.
//    - When 1: sign latching and correction are skipped; the full WIDTH-bit
//      unsigned operands are used.
//    - Divisor 0 then gives LO=all-ones, HI=dividend.
//  - Undefined: port absent; every divide is signed DIV.
// TESTING
//  1. start, 100 / 7 -> after 34 cycles: done pulse, LO=14, HI=2, busy=0.
//  2. start, -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     7 / -2 -> LO=0xFFFFFFFD, HI=1.
//  3. start, 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//     start, 5 / 0 -> LO=0xFFFFFFFF, HI=5.
//  4. Assert is_mf_lo 3 cycles after start -> stall=1 until the done cycle.
//     In the done cycle: hilo_out = new LO, stall=0.
//  5. Drop reset_n at cycle 10 of a divide -> busy=0, done never pulses,
//     MFHI/MFLO read 0. Then 9 / 3 completes normally: LO=3, HI=0.
//  6. HILO_DIVU_EN defined, div_unsigned=1, 0xFFFFFFFF / 2
//     -> LO=0x7FFFFFFF, HI=1.

Source files
------------

// File: rtl/hilo_divider_if.sv
// Execute-stage bus between the pipeline and the HI/LO divider.
// With HILO_DIVU_EN defined the bus carries div_unsigned for DIVU.
interface hilo_divider_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_mf_hi;
  logic             is_mf_lo;
  logic [WIDTH-1:0] hilo_out;
  logic             busy;
  logic             stall;
  logic             done;
`ifdef HILO_DIVU_EN
  logic             div_unsigned;
`endif

  // Pipeline side
  modport master (
    output start, dividend, divisor, is_mf_hi, is_mf_lo,
`ifdef HILO_DIVU_EN
    output div_unsigned,
`endif
    input  hilo_out, busy, stall, done
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor, is_mf_hi, is_mf_lo,
`ifdef HILO_DIVU_EN
    input  div_unsigned,
`endif
    output hilo_out, busy, stall, done
  );
endinterface

// File: rtl/hilo_divider.sv
// hilo_divider: iterative restoring DIV that owns HI/LO and serves MFHI/MFLO.
// Optional macro HILO_DIVU_EN adds an unsigned-divide qualifier (DIVU).
// hilo_out and stall are combinational; busy/done decode the state register.
module hilo_divider #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input logic           clock,
  input logic           reset_n,
  hilo_divider_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / RADIX_BITS;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_uns;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi_src;
  logic [WIDTH-1:0] w_lo_src;
  logic             w_busy;
  logic             w_done;

`ifdef HILO_DIVU_EN
  assign w_uns = bus.div_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  // Operand signs and magnitudes; the most negative value maps to unsigned 2^(W-1)
  assign w_sa    = bus.dividend[WIDTH-1] & ~w_uns;
  assign w_sb    = bus.divisor[WIDTH-1]  & ~w_uns;
  assign w_a_abs = w_sa ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
  assign w_b_abs = w_sb ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_PREP;
      S_PREP: w_next = S_RUN;
      S_RUN:  if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // RADIX_BITS restoring shift-subtract steps per RUN cycle
  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    w_sh     = '0;
    for (int unsigned k = 0; k < RADIX_BITS; k++) begin
      w_sh     = {w_rem_nx, w_quo_nx[WIDTH-1]};
      w_quo_nx = {w_quo_nx[WIDTH-2:0], 1'b0};
      if (w_sh >= {1'b0, r_dvs}) begin
        w_sh        = w_sh - {1'b0, r_dvs};
        w_quo_nx[0] = 1'b1;
      end
      w_rem_nx = w_sh[WIDTH-1:0];
    end
  end

  // Sign correction; a zero divisor forces an all-ones quotient
  always_comb begin
    w_lo = r_quo;
    w_hi = r_rem;
    if (r_dvs == '0)      w_lo = '1;
    else if (r_sa ^ r_sb) w_lo = ~r_quo + WIDTH'(1);
    if (r_sa)             w_hi = ~r_rem + WIDTH'(1);
  end

  // Datapath: operand capture, iteration, HI/LO write-back
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd <= w_a_abs;
            r_dvs <= w_b_abs;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
          end
        end
        S_PREP: begin
          r_rem <= '0;
          r_quo <= r_dvd;
          r_cnt <= CW'(STEPS);
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_hi <= w_hi;
          r_lo <= w_lo;
        end
        default: ;
      endcase
    end
  end

  assign w_busy = (r_state != S_IDLE);
  assign w_done = (r_state == S_FIX);

  // Read port with bypass of the result being written this cycle
  assign w_hi_src = w_done ? w_hi : r_hi;
  assign w_lo_src = w_done ? w_lo : r_lo;

  always_comb begin
    bus.hilo_out = '0;
    if (bus.is_mf_hi)      bus.hilo_out = w_hi_src;
    else if (bus.is_mf_lo) bus.hilo_out = w_lo_src;
  end

  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.stall = (bus.is_mf_hi | bus.is_mf_lo | bus.start) & w_busy & ~w_done;

endmodule
